// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle main control FSM.
// Optional feature macro: MC_ADDI_EN (adds the addi execute/writeback states).
package mc_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned SEL_W    = 2;

  // State encodings; value 15 is unused and recovers to FETCH
  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_ILLEGAL   = 4'd13,
    S_FAULT     = 4'd14
  } state_t;

  // Instruction opcodes (instruction[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  // ALUOp codes, shared with alu_control
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand B selects
  localparam logic [SEL_W-1:0] ASB_B        = 2'b00;
  localparam logic [SEL_W-1:0] ASB_FOUR     = 2'b01;
  localparam logic [SEL_W-1:0] ASB_IMM      = 2'b10;
  localparam logic [SEL_W-1:0] ASB_IMM_SHL2 = 2'b11;

  // PC source selects
  localparam logic [SEL_W-1:0] PCS_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCS_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCS_JUMP   = 2'b10;

  // Datapath control bundle driven by the FSM
  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [SEL_W-1:0]   pc_source;
    logic               illegal_op;
    logic               fault;
  } ctrl_t;

  // States that hold on a memory handshake
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait watchdog: counts consecutive stalled cycles in a handshake
// state and flags a timeout when the limit is reached without mem_ready.
module mc_wait_timer
  import mc_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned WAIT_CNT_W   = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  state_t state,
  input  logic   mem_ready,
  output logic   timeout_c
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT   = WAIT_CNT_W'(MEM_WAIT_MAX);
  localparam logic [WAIT_CNT_W-1:0] CNT_SAT = '1;

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic                  stalled_c;

  // Stalled means a handshake state is waiting and memory has not answered
  assign stalled_c = is_wait_state(state) && !mem_ready;

  // A limit of zero disables the watchdog; mem_ready on the limit cycle wins
  assign timeout_c = (MEM_WAIT_MAX != 0) && stalled_c && (cnt_q == LIMIT);

  // Count stalled cycles; any state change (handshake done or fault) clears
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (stalled_c && !timeout_c) begin
      if (cnt_q != CNT_SAT) begin
        cnt_q <= cnt_q + WAIT_CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle main control FSM for the MIPS-subset datapath.
// Optional feature macro: MC_ADDI_EN (decodes addi into ADDI_EXEC/ADDI_WB;
// when undefined, opcode 001000 is treated as illegal).
module mc_main_control
  import mc_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned WAIT_CNT_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [SEL_W-1:0]    alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [SEL_W-1:0]    pc_source,
  output logic                illegal_op,
  output logic                fault,
  output logic [STATE_W-1:0]  state
);

  state_t state_q;
  ctrl_t  ctrl_c;
  logic   timeout_c;

  mc_wait_timer #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX),
    .WAIT_CNT_W   (WAIT_CNT_W)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .state     (state_q),
    .mem_ready (mem_ready),
    .timeout_c (timeout_c)
  );

  // Instruction class dispatch from DECODE
  function automatic state_t decode_target(input logic [OPCODE_W-1:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:      nxt = S_EXECUTE;
      OP_LW, OP_SW:  nxt = S_MEM_ADDR;
      OP_BEQ:        nxt = S_BRANCH;
      OP_J:          nxt = S_JUMP;
`ifdef MC_ADDI_EN
      OP_ADDI:       nxt = S_ADDI_EXEC;
`else
      OP_ADDI:       nxt = S_ILLEGAL;
`endif
      default:       nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

  // State register and transitions; FAULT is left only through reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      state_q <= S_FETCH;
        S_FETCH: begin
          if (mem_ready)      state_q <= S_DECODE;
          else if (timeout_c) state_q <= S_FAULT;
        end
        S_DECODE:    state_q <= decode_target(opcode);
        S_MEM_ADDR:  state_q <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ: begin
          if (mem_ready)      state_q <= S_MEM_WB;
          else if (timeout_c) state_q <= S_FAULT;
        end
        S_MEM_WB:    state_q <= S_FETCH;
        S_MEM_WRITE: begin
          if (mem_ready)      state_q <= S_FETCH;
          else if (timeout_c) state_q <= S_FAULT;
        end
        S_EXECUTE:   state_q <= S_R_WB;
        S_R_WB:      state_q <= S_FETCH;
        S_BRANCH:    state_q <= S_FETCH;
        S_JUMP:      state_q <= S_FETCH;
`ifdef MC_ADDI_EN
        S_ADDI_EXEC: state_q <= S_ADDI_WB;
        S_ADDI_WB:   state_q <= S_FETCH;
`endif
        S_ILLEGAL:   state_q <= S_FETCH;
        S_FAULT:     state_q <= S_FAULT;
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the state register; only FETCH's IR/PC loads follow mem_ready
  always_comb begin
    ctrl_c = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = ASB_FOUR;
        ctrl_c.alu_op    = ALUOP_ADD;
        ctrl_c.pc_source = PCS_ALU;
        ctrl_c.ir_write  = mem_ready;
        ctrl_c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl_c.alu_src_b = ASB_IMM_SHL2;
        ctrl_c.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = ASB_IMM;
        ctrl_c.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.reg_dst    = 1'b0;
      end
      S_MEM_WRITE: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = ASB_B;
        ctrl_c.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_op        = ALUOP_SUB;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PCS_JUMP;
      end
`ifdef MC_ADDI_EN
      S_ADDI_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = ASB_IMM;
        ctrl_c.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = 1'b0;
      end
`endif
      S_ILLEGAL: begin
        ctrl_c.illegal_op = 1'b1;
      end
      S_FAULT: begin
        ctrl_c.fault = 1'b1;
      end
      default: begin
        ctrl_c = '0;
      end
    endcase
  end

  // Port fan-out of the control bundle
  assign pc_write      = ctrl_c.pc_write;
  assign pc_write_cond = ctrl_c.pc_write_cond;
  assign i_or_d        = ctrl_c.i_or_d;
  assign mem_read      = ctrl_c.mem_read;
  assign mem_write     = ctrl_c.mem_write;
  assign ir_write      = ctrl_c.ir_write;
  assign mem_to_reg    = ctrl_c.mem_to_reg;
  assign reg_dst       = ctrl_c.reg_dst;
  assign reg_write     = ctrl_c.reg_write;
  assign alu_src_a     = ctrl_c.alu_src_a;
  assign alu_src_b     = ctrl_c.alu_src_b;
  assign alu_op        = ctrl_c.alu_op;
  assign pc_source     = ctrl_c.pc_source;
  assign illegal_op    = ctrl_c.illegal_op;
  assign fault         = ctrl_c.fault;
  assign state         = state_q;

endmodule
